result_bank: RTL and testbench



---
 rtl/result_bank.sv | 204 ++++++++++++++++++++
 tb/tb_result_bank.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/result_bank.sv
`default_nettype none
// ============================================================================
//  Module      : result_bank
//  Description : Captures MAC-array result columns into a MAX_DIM x MAX_DIM
//                bank, then streams the row_w x col_x product matrix out
//                serially in row-major order over a valid/ready handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module result_bank #(
  parameter int unsigned DW      = 4,
  parameter int unsigned ACC_W   = 10,
  parameter int unsigned MAX_DIM = 3
) (
  input  logic             clk,
  input  logic             clear_res,
  input  logic [1:0]       row_w,
  input  logic [1:0]       col_x,
  input  logic             mac_valid,
  input  logic [ACC_W-1:0] mac_res1,
  input  logic [ACC_W-1:0] mac_res2,
  input  logic [ACC_W-1:0] mac_res3,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             ovf_err
);

  localparam int unsigned DEPTH = MAX_DIM * MAX_DIM;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_DRAIN   = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  // A product of two DW-bit operands plus growth for the 3-term sum must fit.
  if (ACC_W < 2 * DW + 2) begin : g_acc_w_check
    $error("result_bank: ACC_W too narrow for DW");
  end

  logic [1:0]       state_q,   state_d;
  logic [1:0]       rows_q,    rows_d;
  logic [1:0]       cols_q,    cols_d;
  logic [1:0]       col_cnt_q, col_cnt_d;
  logic [1:0]       rd_row_q,  rd_row_d;
  logic [1:0]       rd_col_q,  rd_col_d;
  logic [ACC_W-1:0] mem_q [DEPTH];
  logic [ACC_W-1:0] mem_d [DEPTH];
  logic [ACC_W-1:0] out_data_q,  out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q,  out_last_d;
  logic             ovf_q,       ovf_d;

  logic             wr_en;
  logic [1:0]       wr_col;
  logic             load_first;
  logic [1:0]       nxt_row;
  logic [1:0]       nxt_col;

  // Row-major flat index into the bank (4-bit, max 8 for legal dimensions).
  function automatic logic [3:0] idx(input logic [1:0] r, input logic [1:0] c);
    return ({2'b00, r} * 4'(MAX_DIM)) + {2'b00, c};
  endfunction

  // Next-state: capture control, drain read pointer and output register.
  always_comb begin
    state_d     = state_q;
    rows_d      = rows_q;
    cols_d      = cols_q;
    col_cnt_d   = col_cnt_q;
    rd_row_d    = rd_row_q;
    rd_col_d    = rd_col_q;
    mem_d       = mem_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    ovf_d       = ovf_q;
    wr_en       = 1'b0;
    wr_col      = col_cnt_q;
    load_first  = 1'b0;
    nxt_row     = rd_row_q;
    nxt_col     = rd_col_q;

    case (state_q)
      S_IDLE: begin
        // A beat with a zero dimension is silently ignored.
        if (mac_valid && (row_w != 2'd0) && (col_x != 2'd0)) begin
          rows_d = row_w;
          cols_d = col_x;
          wr_en  = 1'b1;
          wr_col = 2'd0;
          if (col_x == 2'd1) begin
            state_d    = S_DRAIN;
            load_first = 1'b1;
          end else begin
            col_cnt_d = 2'd1;
            state_d   = S_CAPTURE;
          end
        end
      end
      S_CAPTURE: begin
        if (mac_valid) begin
          wr_en     = 1'b1;
          wr_col    = col_cnt_q;
          col_cnt_d = col_cnt_q + 2'd1;
          if (col_cnt_q == cols_q - 2'd1) begin
            col_cnt_d  = 2'd0;
            state_d    = S_DRAIN;
            load_first = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (mac_valid) begin
          ovf_d = 1'b1;
        end
        if (out_valid_q && out_ready) begin
          if (out_last_q) begin
            state_d     = S_DONE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
          end else begin
            if (rd_col_q == cols_q - 2'd1) begin
              nxt_row = rd_row_q + 2'd1;
              nxt_col = 2'd0;
            end else begin
              nxt_col = rd_col_q + 2'd1;
            end
            rd_row_d   = nxt_row;
            rd_col_d   = nxt_col;
            out_data_d = mem_q[idx(nxt_row, nxt_col)];
            out_last_d = (nxt_row == rows_q - 2'd1) && (nxt_col == cols_q - 2'd1);
          end
        end
      end
      default: begin
        if (mac_valid) begin
          ovf_d = 1'b1;
        end
        state_d = S_IDLE;
      end
    endcase

    // All three result rows are written; rows beyond R are simply never read.
    if (wr_en) begin
      mem_d[idx(2'd0, wr_col)] = mac_res1;
      mem_d[idx(2'd1, wr_col)] = mac_res2;
      mem_d[idx(2'd2, wr_col)] = mac_res3;
    end

    // First element reads the post-write bank so a 1-column capture is seen.
    if (load_first) begin
      rd_row_d    = 2'd0;
      rd_col_d    = 2'd0;
      out_valid_d = 1'b1;
      out_data_d  = mem_d[idx(2'd0, 2'd0)];
      out_last_d  = (rows_d == 2'd1) && (cols_d == 2'd1);
    end
  end

  // State and storage registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (clear_res) begin
      state_q     <= S_IDLE;
      rows_q      <= 2'd0;
      cols_q      <= 2'd0;
      col_cnt_q   <= 2'd0;
      rd_row_q    <= 2'd0;
      rd_col_q    <= 2'd0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      ovf_q       <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      rows_q      <= rows_d;
      cols_q      <= cols_d;
      col_cnt_q   <= col_cnt_d;
      rd_row_q    <= rd_row_d;
      rd_col_q    <= rd_col_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      ovf_q       <= ovf_d;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q == S_CAPTURE) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign ovf_err   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_result_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_result_bank
//  Description : Scoreboard bench for result_bank; directed column beats,
//                expected elements queued at issue, monitor pops on transfer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_result_bank;

  logic       clk = 1'b0;
  logic       clear_res = 1'b1;
  logic [1:0] row_w = 2'd0;
  logic [1:0] col_x = 2'd0;
  logic       mac_valid = 1'b0;
  logic [9:0] mac_res1 = '0;
  logic [9:0] mac_res2 = '0;
  logic [9:0] mac_res3 = '0;
  logic       out_ready = 1'b0;
  logic [9:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       busy;
  logic       done;
  logic       ovf_err;

  result_bank #(.DW(4), .ACC_W(10), .MAX_DIM(3)) dut (
    .clk       (clk),
    .clear_res (clear_res),
    .row_w     (row_w),
    .col_x     (col_x),
    .mac_valid (mac_valid),
    .mac_res1  (mac_res1),
    .mac_res2  (mac_res2),
    .mac_res3  (mac_res3),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .ovf_err   (ovf_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] d;
    logic       l;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;
  int   xfers = 0;
  int   done_cnt = 0;
  logic       held = 1'b0;
  logic [9:0] held_d = '0;
  logic       held_l = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic push_exp(input logic [9:0] d, input logic l);
    exp_t e;
    e.d = d;
    e.l = l;
    q.push_back(e);
  endtask

  // Monitor: pops one expected element per accepted transfer, checks hold.
  always @(negedge clk) begin
    exp_t e;
    if (done) done_cnt++;
    if (out_valid) begin
      if (held) begin
        check("hold_data", out_data, held_d);
        check("hold_last", out_last, held_l);
      end
      if (out_ready) begin
        xfers++;
        held = 1'b0;
        if (q.size() == 0) begin
          checks++;
          $display("FAIL spurious_out: got data %0d, expected no transfer", out_data);
        end else begin
          e = q.pop_front();
          check("out_data", out_data, e.d);
          check("out_last", out_last, e.l);
        end
      end else begin
        held   = 1'b1;
        held_d = out_data;
        held_l = out_last;
      end
    end else begin
      held = 1'b0;
    end
  end

  task automatic beat(input logic [1:0] r, input logic [1:0] c,
                      input logic [9:0] a, input logic [9:0] b, input logic [9:0] d);
    @(posedge clk); #1;
    row_w = r; col_x = c; mac_res1 = a; mac_res2 = b; mac_res3 = d;
    mac_valid = 1'b1;
    @(posedge clk); #1;
    mac_valid = 1'b0;
  endtask

  // mode 0: always ready; mode 1: ready on every third cycle.
  task automatic run_drain(input int mode, output int cycles);
    cycles = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      mac_valid = 1'b0;
      out_ready = (mode == 0) || (i % 3 == 0);
      @(negedge clk);
      if (done) begin
        cycles = i;
        break;
      end
    end
    if (cycles < 0) begin
      checks++;
      $display("FAIL drain_timeout: got no done within 200 cycles, expected done");
    end
    out_ready = 1'b1;
  endtask

  task automatic push_3x3(input int base);
    for (int v = 0; v < 9; v++) push_exp(10'(base + v), v == 8);
  endtask

  task automatic beats_3x3(input int base);
    beat(2'd3, 2'd3, 10'(base + 0), 10'(base + 3), 10'(base + 6));
    beat(2'd3, 2'd3, 10'(base + 1), 10'(base + 4), 10'(base + 7));
    beat(2'd3, 2'd3, 10'(base + 2), 10'(base + 5), 10'(base + 8));
  endtask

  initial begin
    int cyc;
    int x0;
    int d0;

    // Reset state
    repeat (2) @(posedge clk);
    #1 clear_res = 1'b0;
    @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", ovf_err, 0);

    // 3x3 full, always ready
    out_ready = 1'b1;
    push_3x3(1);
    x0 = xfers;
    beats_3x3(1);
    @(negedge clk);
    check("t1_first_valid", out_valid, 1);
    check("t1_busy", busy, 1);
    run_drain(0, cyc);
    check("t1_cycles_to_done", cyc, 9);
    check("t1_xfers", xfers - x0, 9);
    @(negedge clk);
    check("t1_done_one_cycle", done, 0);
    check("t1_busy_after", busy, 0);

    // 2x1 shape: third row never output
    push_exp(10'd10, 1'b0);
    push_exp(10'd20, 1'b1);
    x0 = xfers;
    beat(2'd2, 2'd1, 10'd10, 10'd20, 10'd999);
    @(negedge clk);
    check("t2_first_valid", out_valid, 1);
    run_drain(0, cyc);
    check("t2_cycles_to_done", cyc, 2);
    check("t2_xfers", xfers - x0, 2);

    // Backpressure 1,0,0,1,...
    push_3x3(1);
    x0 = xfers;
    beats_3x3(1);
    @(negedge clk);
    check("t3_first_valid", out_valid, 1);
    run_drain(1, cyc);
    check("t3_cycles_to_done", cyc, 25);
    check("t3_xfers", xfers - x0, 9);

    // Overflow during DRAIN: stream unaffected, error sticky
    push_3x3(11);
    x0 = xfers;
    beats_3x3(11);
    mac_res1 = 10'd1023; mac_res2 = 10'd1023; mac_res3 = 10'd1023;
    mac_valid = 1'b1;
    @(negedge clk);
    check("t4_first_valid", out_valid, 1);
    run_drain(0, cyc);
    check("t4_cycles_to_done", cyc, 9);
    check("t4_xfers", xfers - x0, 9);
    check("t4_ovf_set", ovf_err, 1);
    repeat (3) @(negedge clk);
    check("t4_ovf_sticky", ovf_err, 1);

    // Reset mid-DRAIN after 4 transfers
    for (int v = 0; v < 4; v++) push_exp(10'(21 + v), 1'b0);
    x0 = xfers;
    d0 = done_cnt;
    beats_3x3(21);
    @(negedge clk);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    out_ready = 1'b0;
    clear_res = 1'b1;
    @(posedge clk); #1;
    clear_res = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("t5_valid_after_rst", out_valid, 0);
    check("t5_busy_after_rst", busy, 0);
    check("t5_ovf_cleared", ovf_err, 0);
    check("t5_xfers", xfers - x0, 4);
    repeat (4) @(negedge clk);
    check("t5_no_done", done_cnt - d0, 0);
    push_exp(10'd5, 1'b1);
    beat(2'd1, 2'd1, 10'd5, 10'd0, 10'd0);
    @(negedge clk);
    check("t5_1x1_valid", out_valid, 1);
    run_drain(0, cyc);
    check("t5_1x1_cycles", cyc, 1);

    // Zero dimension: ignored, no error
    x0 = xfers;
    beat(2'd0, 2'd2, 10'd7, 10'd7, 10'd7);
    @(negedge clk);
    check("t6_busy_r0", busy, 0);
    beat(2'd2, 2'd0, 10'd7, 10'd7, 10'd7);
    repeat (3) @(negedge clk);
    check("t6_busy_c0", busy, 0);
    check("t6_valid", out_valid, 0);
    check("t6_ovf", ovf_err, 0);
    check("t6_xfers", xfers - x0, 0);

    check("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
